// File: rtl/es8psk_rec_pkg.sv
// es8psk_rec_pkg: shared FSM state encoding and default sizing for the preamble sync block.
// No ports; imported by preamble_sync_ctrl and peak_tracker.
package es8psk_rec_pkg;
    typedef enum logic [1:0] {IDLE, SEARCH, PEAK, FRAME} sync_state_t;
    localparam int W_DEF        = 20;
    localparam int PEAK_WIN_DEF = 10;
    localparam int CW_DEF       = 16;
endpackage

// File: rtl/peak_tracker.sv
// peak_tracker: running maximum, distance since maximum and window count over valid samples.
// Ports: clk, reset; start loads a fresh window from corr; upd folds corr into the running window;
// max_n/dist_n/win_n are the values after this cycle, so the caller can act on the completing sample.
module peak_tracker
    import es8psk_rec_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int PEAK_WIN = PEAK_WIN_DEF,
    parameter int WW       = $clog2(PEAK_WIN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          upd,
    input  logic [W-1:0]  corr,
    output logic [W-1:0]  max_n,
    output logic [WW-1:0] dist_n,
    output logic [WW-1:0] win_n
);
    logic [W-1:0]  max_q;
    logic [WW-1:0] dist_q;
    logic [WW-1:0] win_q;
    logic          gt;
    always_comb begin
        gt     = corr > max_q;
        max_n  = start ? corr : (upd && gt) ? corr : max_q;
        dist_n = start ? '0 : upd ? (gt ? '0 : dist_q + WW'(1)) : dist_q;
        win_n  = start ? WW'(1) : upd ? win_q + WW'(1) : win_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            max_q  <= '0;
            dist_q <= '0;
            win_q  <= '0;
        end else begin
            max_q  <= max_n;
            dist_q <= dist_n;
            win_q  <= win_n;
        end
    end
endmodule

// File: rtl/preamble_sync_ctrl.sv
// preamble_sync_ctrl: threshold-triggered preamble peak search and frame timing.
// Ports: clk, reset (sync, active-high); corr/corr_vld sample stream; thr threshold; frame_len
// frame length from the peak; arm search enable; sof pulse, peak magnitude, in_frame, sample_idx;
// sync_cnt saturating sof count when PREAMBLE_SYNC_CNT_EN is defined.
module preamble_sync_ctrl
    import es8psk_rec_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int PEAK_WIN = PEAK_WIN_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  corr,
    input  logic          corr_vld,
    input  logic [W-1:0]  thr,
    input  logic [CW-1:0] frame_len,
    input  logic          arm,
    output logic          sof,
    output logic [W-1:0]  peak,
    output logic          in_frame,
`ifdef PREAMBLE_SYNC_CNT_EN
    output logic [15:0]   sync_cnt,
`endif
    output logic [CW-1:0] sample_idx
);
    localparam int WW = $clog2(PEAK_WIN + 1);
    sync_state_t   state, state_n;
    logic          start, upd, fire, last;
    logic [W-1:0]  max_n;
    logic [WW-1:0] dist_n, win_n;
    logic [CW-1:0] flen_q;
    peak_tracker #(.W(W), .PEAK_WIN(PEAK_WIN)) u_trk (
        .clk(clk), .reset(reset), .start(start), .upd(upd), .corr(corr),
        .max_n(max_n), .dist_n(dist_n), .win_n(win_n)
    );
    always_comb begin
        state_n = state;
        start   = 1'b0;
        upd     = 1'b0;
        // frame ends on the valid sample where the index already sits at frame_len-1 (or beyond)
        last    = {1'b0, flen_q} <= {1'b0, sample_idx} + (CW+1)'(1);
        case (state)
            IDLE:   state_n = arm ? SEARCH : IDLE;
            SEARCH: begin
                start   = arm && corr_vld && corr > thr;
                state_n = !arm ? IDLE : start ? PEAK : SEARCH;
            end
            PEAK: begin
                upd     = arm && corr_vld;
                state_n = arm ? PEAK : IDLE;
            end
            FRAME:  state_n = (corr_vld && last) ? (arm ? SEARCH : IDLE) : FRAME;
            default: state_n = IDLE;
        endcase
        fire = (start || upd) && win_n == WW'(PEAK_WIN);
        if (fire) state_n = FRAME;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sof        <= 1'b0;
            peak       <= '0;
            in_frame   <= 1'b0;
            sample_idx <= '0;
            flen_q     <= '0;
        end else begin
            state    <= state_n;
            sof      <= fire;
            in_frame <= state_n == FRAME;
            if (fire) begin
                peak       <= max_n;
                sample_idx <= CW'(dist_n);
                flen_q     <= frame_len;
            end else if (state == FRAME && corr_vld) begin
                sample_idx <= sample_idx + CW'(1);
            end
        end
    end
`ifdef PREAMBLE_SYNC_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) sync_cnt <= '0;
        else if (fire && sync_cnt != 16'hFFFF) sync_cnt <= sync_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_preamble_sync_ctrl.sv
// tb_preamble_sync_ctrl: directed stimulus with a sof scoreboard checked by an independent monitor.
module tb_preamble_sync_ctrl;
    logic        clk = 0, reset = 1, corr_vld = 0, arm = 0;
    logic [19:0] corr = 0, thr = 100;
    logic [15:0] frame_len = 40;
    logic        sof, in_frame;
    logic [19:0] peak;
    logic [15:0] sample_idx;
`ifdef PREAMBLE_SYNC_CNT_EN
    logic [15:0] sync_cnt;
    int          exp_sync = 0;
`endif
    preamble_sync_ctrl dut (
        .clk(clk), .reset(reset), .corr(corr), .corr_vld(corr_vld), .thr(thr),
        .frame_len(frame_len), .arm(arm), .sof(sof), .peak(peak), .in_frame(in_frame),
`ifdef PREAMBLE_SYNC_CNT_EN
        .sync_cnt(sync_cnt),
`endif
        .sample_idx(sample_idx)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] pk;
        logic [15:0] idx;
        int          len;
        logic [15:0] last;
    } exp_t;
    exp_t        q[$];
    exp_t        cur;
    int          n_chk = 0, n_fail = 0, n_sof = 0, n_exp = 0, fcnt = 0;
    bit          meas = 0;
    logic [15:0] prev_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [19:0] pk, input logic [15:0] idx, input int len, input logic [15:0] last);
        exp_t e;
        e.pk = pk; e.idx = idx; e.len = len; e.last = last;
        q.push_back(e);
        n_exp++;
`ifdef PREAMBLE_SYNC_CNT_EN
        exp_sync++;
`endif
    endtask

    task automatic send(input logic [19:0] c, input logic v);
        corr = c; corr_vld = v;
        @(posedge clk); #1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) send(50, 1);
    endtask

    task automatic trig(input logic [19:0] p);
        send(p, 1);
        for (int i = 0; i < 9; i++) send(50, 1);
    endtask

    always @(negedge clk) begin
        if (meas) begin
            if (in_frame) begin
                fcnt++;
                prev_idx = sample_idx;
            end else begin
                chk("frame_cycles", fcnt, cur.len);
                chk("last_idx", prev_idx, cur.last);
                meas = 0;
            end
        end
        if (sof) begin
            n_sof++;
            chk("sof_count", n_sof, n_exp);
            if (q.size() > 0) begin
                cur = q.pop_front();
                chk("peak", peak, cur.pk);
                chk("sof_idx", sample_idx, cur.idx);
                chk("in_frame_at_sof", in_frame, 1);
                meas = 1;
                fcnt = 1;
                prev_idx = sample_idx;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sof", sof, 0);
        chk("rst_in_frame", in_frame, 0);
        chk("rst_peak", peak, 0);
        chk("rst_idx", sample_idx, 0);
        @(posedge clk); #1;
        reset = 0; arm = 1;
        // basic detection: peak 300 two samples in, frame 40 from peak
        push(300, 8, 32, 39);
        send(0, 1); send(0, 1); send(0, 1);
        send(150, 1); send(300, 1); send(200, 1);
        fill(60);
        // equal to threshold never triggers
        for (int i = 0; i < 20; i++) send(100, 1);
        chk("no_trig_eq_thr", n_sof, n_exp);
        chk("no_trig_in_frame", in_frame, 0);
        // equal maxima keep the earlier one; frame_len latched at sof
        frame_len = 20;
        push(500, 7, 13, 19);
        send(150, 1); send(200, 1); send(500, 1); send(50, 1); send(50, 1);
        send(500, 1); send(50, 1); send(50, 1); send(50, 1); send(50, 1);
        frame_len = 0;
        fill(30);
        // gapped valid strobe: invalid samples neither count nor update max
        frame_len = 20;
        push(400, 9, 22, 19);
        send(400, 1);
        for (int i = 0; i < 30; i++) begin send(999, 0); send(50, 1); end
        fill(10);
        // threshold crossings inside a frame are ignored
        frame_len = 15;
        push(200, 9, 6, 14);
        trig(200);
        for (int i = 0; i < 4; i++) send(900, 1);
        fill(30);
        // arm dropped during PEAK aborts without sof
        send(300, 1); fill(3);
        arm = 0; fill(2);
        arm = 1; fill(20);
        chk("arm_drop_peak", n_sof, n_exp);
        // arm dropped during FRAME lets the frame finish
        frame_len = 16;
        push(250, 9, 7, 15);
        trig(250);
        fill(2);
        arm = 0;
        fill(20);
        for (int i = 0; i < 3; i++) send(900, 1);
        chk("arm_drop_frame", n_sof, n_exp);
        arm = 1;
        fill(5);
        // frame_len 0 ends on the first frame sample
        frame_len = 0;
        push(150, 9, 1, 9);
        trig(150);
        fill(10);
        // peak on the window's last sample, frame_len 1
        frame_len = 1;
        push(600, 0, 1, 0);
        for (int i = 0; i < 9; i++) send(150, 1);
        send(600, 1);
        fill(10);
        // reset mid-frame, then resume
        frame_len = 40;
        push(150, 9, 4, 12);
        trig(150);
        fill(3);
        reset = 1;
        send(50, 1);
        reset = 0;
`ifdef PREAMBLE_SYNC_CNT_EN
        exp_sync = 0;
`endif
        @(negedge clk);
        chk("mid_rst_sof", sof, 0);
        chk("mid_rst_in_frame", in_frame, 0);
        chk("mid_rst_peak", peak, 0);
        chk("mid_rst_idx", sample_idx, 0);
        frame_len = 12;
        fill(1);
        push(700, 9, 3, 11);
        trig(700);
        fill(20);
        chk("sof_total", n_sof, n_exp);
        chk("queue_drained", q.size(), 0);
`ifdef PREAMBLE_SYNC_CNT_EN
        chk("sync_cnt", sync_cnt, exp_sync);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
